// File: rtl/text_memory_loader.sv
`default_nettype none
// text_memory_loader: length-prefixed byte stream -> sequential 32-bit text memory writes.
// Optional trailing XOR checksum byte when LOADER_CHECKSUM_EN is defined.
module text_memory_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int MAX_WORDS  = 2**ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_address,
  output logic [31:0]           wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic                  cpu_hold
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_DATA  = 3'd2,
    S_CSUM  = 3'd3,
    S_DONE  = 3'd4,
    S_ERROR = 3'd5
  } state_t;

`ifdef LOADER_CHECKSUM_EN
  localparam state_t S_AFTER_DATA = S_CSUM;
`else
  localparam state_t S_AFTER_DATA = S_DONE;
`endif

  state_t                state;
  state_t                state_next;
  logic [1:0]            byte_cnt;
  logic [23:0]           asm_bytes;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [ADDR_WIDTH-1:0] last_idx;
  logic [31:0]           wr_data_q;
  logic                  wr_en_q;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]            csum_acc;
`endif

  logic                  xfer;
  logic                  last_byte;
  logic [31:0]           len_word;
  logic                  len_zero;
  logic                  len_over;
  logic [ADDR_WIDTH-1:0] len_last_idx;
  logic                  restart;

  assign xfer         = in_valid & in_ready;
  assign last_byte    = xfer & (byte_cnt == 2'd3);
  assign len_word     = {in_data, asm_bytes};
  assign len_zero     = (len_word == 32'd0);
  assign len_over     = ({1'b0, len_word} > 33'(MAX_WORDS));
  // N == MAX_WORDS wraps the low bits to zero, and zero minus one is MAX_WORDS-1.
  assign len_last_idx = len_word[ADDR_WIDTH-1:0] - ADDR_WIDTH'(1);
  assign restart      = start & ~busy;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_next = S_LEN;
      end
      S_LEN: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (last_byte) begin
          if (len_over)      state_next = S_ERROR;
          else if (len_zero) state_next = S_AFTER_DATA;
          else               state_next = S_DATA;
        end
      end
      S_DATA: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (last_byte && (word_idx == last_idx)) state_next = S_AFTER_DATA;
      end
      S_CSUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
`ifdef LOADER_CHECKSUM_EN
        if (xfer) state_next = (in_data == csum_acc) ? S_DONE : S_ERROR;
`else
        state_next = S_DONE;
`endif
      end
      S_DONE: begin
        done = 1'b1;
        if (start) state_next = S_LEN;
      end
      S_ERROR: begin
        error = 1'b1;
        if (start) state_next = S_LEN;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign cpu_hold = busy | error;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      byte_cnt  <= 2'd0;
      asm_bytes <= 24'd0;
      word_idx  <= '0;
      last_idx  <= '0;
      wr_data_q <= 32'd0;
      wr_en_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_acc  <= 8'd0;
`endif
    end else begin
      wr_en_q <= 1'b0;
      // The final word's index is kept so wr_address never runs past N-1.
      if (wr_en_q && (word_idx != last_idx)) word_idx <= word_idx + ADDR_WIDTH'(1);
      if (restart) begin
        byte_cnt  <= 2'd0;
        asm_bytes <= 24'd0;
        word_idx  <= '0;
        last_idx  <= '0;
`ifdef LOADER_CHECKSUM_EN
        csum_acc  <= 8'd0;
`endif
      end else if (xfer && (state != S_CSUM)) begin
        byte_cnt  <= byte_cnt + 2'd1;
        asm_bytes <= {in_data, asm_bytes[23:8]};
        if ((state == S_LEN) && (byte_cnt == 2'd3)) begin
          last_idx <= len_last_idx;
        end
        if (state == S_DATA) begin
`ifdef LOADER_CHECKSUM_EN
          csum_acc <= csum_acc ^ in_data;
`endif
          if (byte_cnt == 2'd3) begin
            wr_en_q   <= 1'b1;
            wr_data_q <= len_word;
          end
        end
      end
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_data    = wr_data_q;
  assign wr_address = word_idx;

endmodule
`default_nettype wire
